tetris_game_ctrl: RTL and testbench

Sequencing controller for the 4-wide by 8-tall board datapath. Owns the locked-board register and the active-piece mask. Runs one game: spawn a piece, move it left/right, apply gravity on a tick, lock it, then clear full rows one per cycle. Drives the composite board to the display side and flags game over when a spawn collides.

---
 rtl/tetris_pkg.sv | 47 ++++
 rtl/tetris_game_ctrl_row_collapse.sv | 40 ++++
 rtl/tetris_game_ctrl.sv | 126 ++++++++++++
 tb/tb_tetris_game_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared geometry, piece encodings, spawn masks, state enum and
// column masks for the 4-wide by 8-tall board controller.
package tetris_pkg;

  localparam int unsigned ROWS      = 8;
  localparam int unsigned COLS      = 4;
  localparam int unsigned CELLS     = ROWS * COLS;
  localparam int unsigned ROW_IDX_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    PIECE_DOT    = 2'b00,
    PIECE_BAR    = 2'b01,
    PIECE_SQUARE = 2'b10,
    PIECE_L      = 2'b11
  } piece_e;

  // Spawn masks, cell index = 4*row + col, row 0 at the top
  localparam logic [CELLS-1:0] MASK_DOT    = 32'h0000_0002;
  localparam logic [CELLS-1:0] MASK_BAR    = 32'h0000_0006;
  localparam logic [CELLS-1:0] MASK_SQUARE = 32'h0000_0066;
  localparam logic [CELLS-1:0] MASK_L      = 32'h0000_0062;

  localparam logic [CELLS-1:0] COL0_MASK = 32'h1111_1111;
  localparam logic [CELLS-1:0] COL3_MASK = 32'h8888_8888;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    LOCK  = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } state_e;

  // Map a piece selector to its spawn mask
  function automatic logic [CELLS-1:0] spawn_mask(input logic [1:0] sel);
    logic [CELLS-1:0] m;
    case (piece_e'(sel))
      PIECE_DOT:    m = MASK_DOT;
      PIECE_BAR:    m = MASK_BAR;
      PIECE_SQUARE: m = MASK_SQUARE;
      default:      m = MASK_L;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tetris_game_ctrl_row_collapse.sv
// row_collapse: combinational full-row removal.
//   board     - locked board
//   found     - at least one full row exists
//   collapsed - board with the bottom-most full row removed, rows above it
//               shifted down one, row 0 zeroed (equals board when !found)
module row_collapse
  import tetris_pkg::*;
(
  input  logic [CELLS-1:0] board,
  output logic             found,
  output logic [CELLS-1:0] collapsed
);

  logic [ROW_IDX_W-1:0] idx;

  // Last match wins, so idx ends on the highest-index (bottom-most) full row
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (board[r*COLS +: COLS] == {COLS{1'b1}}) begin
        found = 1'b1;
        idx   = ROW_IDX_W'(r);
      end
    end
  end

  always_comb begin
    collapsed = board;
    if (found) begin
      for (int r = 1; r < ROWS; r++) begin
        if (ROW_IDX_W'(r) <= idx) begin
          collapsed[r*COLS +: COLS] = board[(r-1)*COLS +: COLS];
        end
      end
      collapsed[0 +: COLS] = '0;
    end
  end

endmodule

// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: sequencing controller for a 4x8 board. Owns the locked
// board and active-piece mask; spawns, moves, drops, locks and clears rows.
//   clka, rst        - clock, async active-high reset
//   start            - begin a new game (IDLE/OVER only)
//   tick             - gravity pulse (FALL only)
//   btn_left/right   - move requests (FALL only)
//   piece_sel        - shape sampled in SPAWN
//   board_out        - locked board OR active mask
//   game_over        - high in OVER
//   lines            - saturating cleared-row count
//   busy             - high in LOCK/CLEAR/SPAWN
module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned LINES_W = 8
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic [1:0]         piece_sel,
  output logic [CELLS-1:0]   board_out,
  output logic               game_over,
  output logic [LINES_W-1:0] lines,
  output logic               busy
);

  state_e             state, state_d;
  logic [CELLS-1:0]   board, board_d;
  logic [CELLS-1:0]   mask, mask_d;
  logic [LINES_W-1:0] lines_d;
  logic [CELLS-1:0]   spawn;
  logic               row_found;
  logic [CELLS-1:0]   board_collapsed;

  row_collapse u_row_collapse (
    .board     (board),
    .found     (row_found),
    .collapsed (board_collapsed)
  );

  assign spawn = spawn_mask(piece_sel);

  // State and datapath registers
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      board <= '0;
      mask  <= '0;
      lines <= '0;
    end else begin
      state <= state_d;
      board <= board_d;
      mask  <= mask_d;
      lines <= lines_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state;
    board_d = board;
    mask_d  = mask;
    lines_d = lines;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          board_d = '0;
          mask_d  = '0;
          lines_d = '0;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        if ((spawn & board) != '0) begin
          mask_d  = '0;
          state_d = OVER;
        end else begin
          mask_d  = spawn;
          state_d = FALL;
        end
      end
      FALL: begin
        // Gravity wins over any simultaneous move
        if (tick) begin
          if ((mask[CELLS-1 -: COLS] != '0) || (((mask << COLS) & board) != '0)) begin
            state_d = LOCK;
          end else begin
            mask_d = mask << COLS;
          end
        end else if (btn_left && !btn_right) begin
          if (((mask & COL0_MASK) == '0) && (((mask >> 1) & board) == '0)) begin
            mask_d = mask >> 1;
          end
        end else if (btn_right && !btn_left) begin
          if (((mask & COL3_MASK) == '0) && (((mask << 1) & board) == '0)) begin
            mask_d = mask << 1;
          end
        end
      end
      LOCK: begin
        board_d = board | mask;
        mask_d  = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        if (row_found) begin
          board_d = board_collapsed;
          if (lines != {LINES_W{1'b1}}) begin
            lines_d = lines + LINES_W'(1);
          end
        end else begin
          state_d = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign board_out = board | mask;
  assign game_over = (state == OVER);
  assign busy      = (state == LOCK) || (state == CLEAR) || (state == SPAWN);

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// tb_tetris_game_ctrl: directed self-checking bench for tetris_game_ctrl.
module tb_tetris_game_ctrl;
  import tetris_pkg::*;

  logic        clka;
  logic        rst;
  logic        start;
  logic        tick;
  logic        btn_left;
  logic        btn_right;
  logic [1:0]  piece_sel;
  logic [31:0] board_out;
  logic        game_over;
  logic [7:0]  lines;
  logic        busy;

  int n_cmp;
  int n_bad;

  tetris_game_ctrl #(.LINES_W(8)) dut (
    .clka      (clka),
    .rst       (rst),
    .start     (start),
    .tick      (tick),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .piece_sel (piece_sel),
    .board_out (board_out),
    .game_over (game_over),
    .lines     (lines),
    .busy      (busy)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // One cycle of inputs; entered and left on a falling edge
  task automatic step(input logic t, input logic l, input logic r);
    tick = t; btn_left = l; btn_right = r;
    @(negedge clka);
    tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clka);
    rst = 1'b0;
    @(negedge clka);
  endtask

  // start -> SPAWN -> FALL with the piece visible
  task automatic new_game(input logic [1:0] sel);
    piece_sel = sel;
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    @(negedge clka);
  endtask

  // Two squares side by side at rows 6-7, second one one tick short of locking
  task automatic setup_double_clear;
    do_reset;
    new_game(2'b10);
    step(0, 1, 0);
    repeat (7) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(0, 0, 1);
    repeat (6) step(1, 0, 0);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (board_out !== 32'h0) begin n_bad++; $display("FAIL reset_board got=%h exp=%h", board_out, 32'h0); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
    n_cmp++; if (lines !== 8'h0) begin n_bad++; $display("FAIL reset_lines got=%0d exp=0", lines); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clka);
    rst = 1'b0;
    @(negedge clka);
  endtask

  task automatic test_free_fall;
    int n;
    do_reset;
    new_game(2'b10);
    n_cmp++; if (board_out !== 32'h0000_0066) begin n_bad++; $display("FAIL ff_spawn got=%h exp=%h", board_out, 32'h66); end
    repeat (6) step(1, 0, 0);
    n_cmp++; if (board_out !== 32'h6600_0000) begin n_bad++; $display("FAIL ff_bottom got=%h exp=%h", board_out, 32'h6600_0000); end
    step(1, 0, 0);
    n = 0;
    while (busy && n < 10) begin
      n++;
      step(0, 0, 0);
    end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL ff_busy_cycles got=%0d exp=3", n); end
    n_cmp++; if (lines !== 8'd0) begin n_bad++; $display("FAIL ff_lines got=%0d exp=0", lines); end
    n_cmp++; if (board_out !== 32'h6600_0066) begin n_bad++; $display("FAIL ff_respawn got=%h exp=%h", board_out, 32'h6600_0066); end
  endtask

  task automatic test_walls;
    do_reset;
    new_game(2'b01);
    n_cmp++; if (board_out !== 32'h6) begin n_bad++; $display("FAIL wall_spawn got=%h exp=%h", board_out, 32'h6); end
    step(0, 1, 0);
    n_cmp++; if (board_out !== 32'h3) begin n_bad++; $display("FAIL wall_left1 got=%h exp=%h", board_out, 32'h3); end
    step(0, 1, 0);
    n_cmp++; if (board_out !== 32'h3) begin n_bad++; $display("FAIL wall_left2 got=%h exp=%h", board_out, 32'h3); end
    do_reset;
    new_game(2'b01);
    step(0, 0, 1);
    n_cmp++; if (board_out !== 32'hC) begin n_bad++; $display("FAIL wall_right1 got=%h exp=%h", board_out, 32'hC); end
    step(0, 0, 1);
    step(0, 0, 1);
    n_cmp++; if (board_out !== 32'hC) begin n_bad++; $display("FAIL wall_right3 got=%h exp=%h", board_out, 32'hC); end
  endtask

  task automatic test_priority;
    do_reset;
    new_game(2'b10);
    step(1, 1, 0);
    n_cmp++; if (board_out !== 32'h660) begin n_bad++; $display("FAIL prio_tick_left got=%h exp=%h", board_out, 32'h660); end
    step(0, 1, 1);
    n_cmp++; if (board_out !== 32'h660) begin n_bad++; $display("FAIL prio_both got=%h exp=%h", board_out, 32'h660); end
    step(0, 0, 1);
    n_cmp++; if (board_out !== 32'hCC0) begin n_bad++; $display("FAIL prio_right got=%h exp=%h", board_out, 32'hCC0); end
    step(0, 1, 0);
    n_cmp++; if (board_out !== 32'h660) begin n_bad++; $display("FAIL prio_left got=%h exp=%h", board_out, 32'h660); end
  endtask

  task automatic test_double_clear;
    setup_double_clear;
    n_cmp++; if (board_out !== 32'hFF00_0000) begin n_bad++; $display("FAIL dc_before got=%h exp=%h", board_out, 32'hFF00_0000); end
    step(1, 0, 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dc_lock_busy got=%b exp=1", busy); end
    step(0, 1, 0);
    n_cmp++; if (board_out !== 32'hFF00_0000) begin n_bad++; $display("FAIL dc_clear1 got=%h exp=%h", board_out, 32'hFF00_0000); end
    step(0, 1, 0);
    n_cmp++; if (board_out !== 32'hF000_0000 || lines !== 8'd1) begin n_bad++; $display("FAIL dc_clear2 got=%h/%0d exp=%h/1", board_out, lines, 32'hF000_0000); end
    step(0, 1, 0);
    n_cmp++; if (board_out !== 32'h0 || lines !== 8'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL dc_clear3 got=%h/%0d/%b exp=0/2/1", board_out, lines, busy); end
    step(0, 1, 0);
    n_cmp++; if (busy !== 1'b1 || board_out !== 32'h0) begin n_bad++; $display("FAIL dc_spawn got=%b/%h exp=1/0", busy, board_out); end
    step(0, 1, 0);
    n_cmp++; if (busy !== 1'b0 || board_out !== 32'h66 || lines !== 8'd2) begin n_bad++; $display("FAIL dc_after got=%b/%h/%0d exp=0/66/2", busy, board_out, lines); end
  endtask

  task automatic test_reset_mid_clear;
    setup_double_clear;
    step(1, 0, 0);
    step(0, 0, 0);
    n_cmp++; if (board_out !== 32'hFF00_0000 || busy !== 1'b1) begin n_bad++; $display("FAIL rmc_pre got=%h/%b exp=ff000000/1", board_out, busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (board_out !== 32'h0) begin n_bad++; $display("FAIL rmc_board got=%h exp=0", board_out); end
    n_cmp++; if (busy !== 1'b0 || game_over !== 1'b0 || lines !== 8'd0) begin n_bad++; $display("FAIL rmc_outs got=%b/%b/%0d exp=0/0/0", busy, game_over, lines); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL rmc_state got=%0d exp=%0d", dut.state, IDLE); end
    rst = 1'b0;
    @(negedge clka);
  endtask

  task automatic test_game_over;
    int exp_ticks [4];
    int ticks;
    int nb;
    exp_ticks = '{7, 5, 3, 1};
    do_reset;
    new_game(2'b10);
    for (int s = 0; s < 4; s++) begin
      ticks = 0;
      while (ticks < 12 && !busy) begin
        step(1, 0, 0);
        ticks++;
      end
      nb = 0;
      while (busy && nb < 10) begin
        step(0, 0, 0);
        nb++;
      end
      n_cmp++; if (ticks !== exp_ticks[s]) begin n_bad++; $display("FAIL go_ticks%0d got=%0d exp=%0d", s, ticks, exp_ticks[s]); end
      n_cmp++; if (nb !== 3) begin n_bad++; $display("FAIL go_busy%0d got=%0d exp=3", s, nb); end
    end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL go_flag got=%b exp=1", game_over); end
    n_cmp++; if (board_out !== 32'h6666_6666) begin n_bad++; $display("FAIL go_board got=%h exp=%h", board_out, 32'h6666_6666); end
    step(1, 1, 0);
    n_cmp++; if (board_out !== 32'h6666_6666 || game_over !== 1'b1) begin n_bad++; $display("FAIL go_hold got=%h/%b exp=66666666/1", board_out, game_over); end
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    n_cmp++; if (board_out !== 32'h0 || game_over !== 1'b0) begin n_bad++; $display("FAIL go_restart got=%h/%b exp=0/0", board_out, game_over); end
    @(negedge clka);
    n_cmp++; if (board_out !== 32'h66) begin n_bad++; $display("FAIL go_newpiece got=%h exp=%h", board_out, 32'h66); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    tick = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    piece_sel = 2'b00;
    test_reset;
    test_free_fall;
    test_walls;
    test_priority;
    test_double_clear;
    test_reset_mid_clear;
    test_game_over;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
